// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
// - ADDR_W / INST_W : default address and instruction widths
// - DEFAULT_RESET_PC: PC loaded on reset unless the top overrides it
// - fetch_state_e   : fetch FSM encoding
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle between the fetch unit and its surroundings.
// - Imem_*     : req/ack read port to instruction memory
// - Redirect*  : branch/jump redirect from execute
// - Inst*      : valid/ready handshake towards decode
// modport master: fetch unit side; modport slave: memory/decode/execute side.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INST_W = cpu_pkg::INST_W
);

  logic              Imem_req;
  logic [ADDR_W-1:0] Imem_addr;
  logic              Imem_ack;
  logic [INST_W-1:0] Imem_rdata;

  logic              Redirect;
  logic [ADDR_W-1:0] Redirect_pc;

  logic              Inst_valid;
  logic              Inst_ready;
  logic [INST_W-1:0] Inst;
  logic [ADDR_W-1:0] Inst_pc;

  modport master (
    output Imem_req, Imem_addr,
    input  Imem_ack, Imem_rdata,
    input  Redirect, Redirect_pc,
    output Inst_valid, Inst, Inst_pc,
    input  Inst_ready
  );

  modport slave (
    input  Imem_req, Imem_addr,
    output Imem_ack, Imem_rdata,
    output Redirect, Redirect_pc,
    input  Inst_valid, Inst, Inst_pc,
    output Inst_ready
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter datapath of the fetch unit.
// - clk, rst_n     : clock, asynchronous active-low reset
// - in_fetch_i     : FSM is in S_FETCH (a memory read is outstanding)
// - ack_i          : memory returned data this cycle
// - redirect_i     : redirect pulse from execute
// - redirect_pc_i  : redirect target (low two bits ignored)
// - pc_o           : current fetch PC, also the memory address
// - squash_o       : outstanding read belongs to a stale path
module fetch_pc_reg #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_fetch_i,
  input  logic              ack_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              squash_o
);

  import cpu_pkg::*;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              squash_q, squash_d;
  logic [ADDR_W-1:0] redirect_aligned;

  // Masking rather than slicing keeps every target bit in use.
  assign redirect_aligned = redirect_pc_i & ~ADDR_W'(3);

  // NOTE: every variable written here gets a default first, so no path
  // through the if-chain leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_d     = pc_q;
    target_d = target_q;
    squash_d = squash_q;
    if (in_fetch_i && !ack_i) begin
      // The address must not move while the read is outstanding: park the
      // target and drop the data when it eventually arrives.
      if (redirect_i) begin
        target_d = redirect_aligned;
        squash_d = 1'b1;
      end
    end else if (redirect_i) begin
      // Idle, hold, or fetch with ack: redirect wins over pc+4 and any
      // parked target.
      pc_d     = redirect_aligned;
      squash_d = 1'b0;
    end else if (in_fetch_i) begin
      if (squash_q) begin
        pc_d     = target_q;
        squash_d = 1'b0;
      end else begin
        pc_d = pc_q + ADDR_W'(4);  // wraps modulo 2^ADDR_W
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
      squash_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      target_q <= target_d;
      squash_q <= squash_d;
    end
  end

  assign pc_o     = pc_q;
  assign squash_o = squash_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory with a
// req/ack handshake and offers each word with its PC to decode.
// - Clk  : rising-edge clock
// - Clrn : asynchronous active-low reset
// - bus  : inst_fetch_unit_if.master (memory port, redirect, decode port)
// All outputs come from registers or from the state register alone.
module inst_fetch_unit #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INST_W   = cpu_pkg::INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::DEFAULT_RESET_PC)
) (
  input  logic               Clk,
  input  logic               Clrn,
  inst_fetch_unit_if.master  bus
);

  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

  logic [ADDR_W-1:0] pc;
  logic              squash;
  logic              in_fetch;
  logic              accept;

  assign in_fetch = (state_q == S_FETCH);

  // Returned data is kept only if it belongs to the current path.
  assign accept = in_fetch && bus.Imem_ack && !bus.Redirect && !squash;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (Clk),
    .rst_n         (Clrn),
    .in_fetch_i    (in_fetch),
    .ack_i         (bus.Imem_ack),
    .redirect_i    (bus.Redirect),
    .redirect_pc_i (bus.Redirect_pc),
    .pc_o          (pc),
    .squash_o      (squash)
  );

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (accept) begin
          state_d   = S_HOLD;
          inst_d    = bus.Imem_rdata;
          inst_pc_d = pc;
        end
      end
      S_HOLD: begin
        // A redirect alongside ready still lets decode take the word.
        if (bus.Inst_ready || bus.Redirect) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q   <= S_IDLE;
      // NOTE: the instruction holding registers are reset too, so decode
      // never sees X on Inst/Inst_pc even before the first fetch.
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign bus.Imem_req   = in_fetch;
  assign bus.Imem_addr  = pc;  // pc is frozen while a read is outstanding
  assign bus.Inst_valid = (state_q == S_HOLD);
  assign bus.Inst       = inst_q;
  assign bus.Inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_inst_fetch_unit;

  logic Clk = 1'b0;
  logic Clrn;
  int   checks = 0;
  int   failures = 0;
  int   xfer_count = 0;

  always #5 Clk = ~Clk;

  inst_fetch_unit_if bus ();

  inst_fetch_unit dut (
    .Clk  (Clk),
    .Clrn (Clrn),
    .bus  (bus)
  );

  // Decode-side transfer counter.
  always @(posedge Clk)
    if (Clrn && bus.Inst_valid && bus.Inst_ready) xfer_count++;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drive_idle();
    bus.Imem_ack    = 1'b0;
    bus.Imem_rdata  = '0;
    bus.Redirect    = 1'b0;
    bus.Redirect_pc = '0;
    bus.Inst_ready  = 1'b0;
  endtask

  // Leaves the DUT in its first S_FETCH cycle at the reset PC.
  task automatic do_reset();
    Clrn = 1'b0;
    drive_idle();
    @(negedge Clk);
    @(negedge Clk);
    Clrn = 1'b1;
    step();
  endtask

  // Expects a request at addr, acks it at once and checks the presented word.
  task automatic do_fetch(input logic [31:0] addr);
    checks++;
    if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== addr) begin
      failures++;
      $display("FAIL fetch_req: req=%b addr=%h, expected req=1 addr=%h",
               bus.Imem_req, bus.Imem_addr, addr);
    end
    bus.Imem_ack   = 1'b1;
    bus.Imem_rdata = mem_data(addr);
    step();
    bus.Imem_ack   = 1'b0;
    bus.Imem_rdata = '0;
    checks++;
    if (bus.Inst_valid !== 1'b1 || bus.Inst_pc !== addr ||
        bus.Inst !== mem_data(addr) || bus.Imem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_out: valid=%b pc=%h inst=%h req=%b, expected 1 %h %h 0",
               bus.Inst_valid, bus.Inst_pc, bus.Inst, bus.Imem_req, addr, mem_data(addr));
    end
  endtask

  task automatic test_reset();
    Clrn = 1'b0;
    drive_idle();
    @(negedge Clk);
    checks++;
    if (bus.Imem_req !== 1'b0 || bus.Imem_addr !== 32'h0 || bus.Inst_valid !== 1'b0 ||
        bus.Inst !== 32'h0 || bus.Inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_values: req=%b addr=%h valid=%b inst=%h pc=%h, expected all 0",
               bus.Imem_req, bus.Imem_addr, bus.Inst_valid, bus.Inst, bus.Inst_pc);
    end
    Clrn = 1'b1;
    step();
    checks++;
    if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_first_req: req=%b addr=%h, expected req=1 addr=00000000",
               bus.Imem_req, bus.Imem_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    bus.Inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_fetch(32'(4 * k));
      step();
      checks++;
      if (bus.Inst_valid !== 1'b0) begin
        failures++;
        $display("FAIL stream_pulse: valid=%b at k=%0d, expected 0", bus.Inst_valid, k);
      end
    end
  endtask

  task automatic test_backpressure();
    int x0;
    do_reset();
    bus.Inst_ready = 1'b1;
    do_fetch(32'h0);
    step();
    bus.Inst_ready = 1'b0;
    do_fetch(32'h4);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.Inst_valid !== 1'b1 || bus.Inst_pc !== 32'h4 ||
          bus.Inst !== mem_data(32'h4) || bus.Imem_req !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d valid=%b pc=%h inst=%h req=%b, expected 1 00000004 %h 0",
                 i, bus.Inst_valid, bus.Inst_pc, bus.Inst, bus.Imem_req, mem_data(32'h4));
      end
    end
    bus.Inst_ready = 1'b1;
    x0 = xfer_count;
    step();
    checks++;
    if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h8 || bus.Inst_valid !== 1'b0 ||
        xfer_count - x0 !== 1) begin
      failures++;
      $display("FAIL bp_release: req=%b addr=%h valid=%b xfers=%0d, expected 1 00000008 0 1",
               bus.Imem_req, bus.Imem_addr, bus.Inst_valid, xfer_count - x0);
    end
  endtask

  task automatic test_redirect_fetch();
    do_reset();
    bus.Inst_ready = 1'b1;
    do_fetch(32'h0);
    step();
    do_fetch(32'h4);
    step();
    step();  // second cycle of the unacked request at 8
    bus.Redirect    = 1'b1;
    bus.Redirect_pc = 32'h100;
    step();
    bus.Redirect    = 1'b0;
    bus.Redirect_pc = '0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h8 || bus.Inst_valid !== 1'b0) begin
        failures++;
        $display("FAIL redir_addr_stable: req=%b addr=%h valid=%b, expected 1 00000008 0",
                 bus.Imem_req, bus.Imem_addr, bus.Inst_valid);
      end
      if (i == 0) step();
    end
    bus.Imem_ack   = 1'b1;
    bus.Imem_rdata = mem_data(32'h8);
    step();
    bus.Imem_ack   = 1'b0;
    bus.Imem_rdata = '0;
    checks++;
    if (bus.Inst_valid !== 1'b0 || bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL redir_drop: valid=%b req=%b addr=%h, expected 0 1 00000100",
               bus.Inst_valid, bus.Imem_req, bus.Imem_addr);
    end
    do_fetch(32'h100);
  endtask

  task automatic test_redirect_hold();
    int x0;
    do_reset();
    do_fetch(32'h0);
    step();
    bus.Inst_ready  = 1'b1;
    bus.Redirect    = 1'b1;
    bus.Redirect_pc = 32'h203;
    x0 = xfer_count;
    step();
    bus.Redirect    = 1'b0;
    bus.Redirect_pc = '0;
    checks++;
    if (bus.Inst_valid !== 1'b0 || bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h200) begin
      failures++;
      $display("FAIL hold_redir_addr: valid=%b req=%b addr=%h, expected 0 1 00000200",
               bus.Inst_valid, bus.Imem_req, bus.Imem_addr);
    end
    step();
    checks++;
    if (xfer_count - x0 !== 1) begin
      failures++;
      $display("FAIL hold_redir_xfer: transfers=%0d, expected 1", xfer_count - x0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.Inst_ready = 1'b1;
    do_fetch(32'h0);
    bus.Redirect    = 1'b1;
    bus.Redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.Redirect    = 1'b0;
    bus.Redirect_pc = '0;
    do_fetch(32'hFFFF_FFFC);
    step();
    checks++;
    if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap: req=%b addr=%h, expected req=1 addr=00000000",
               bus.Imem_req, bus.Imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.Inst_ready = 1'b1;
    do_fetch(32'h0);
    step();
    do_fetch(32'h4);
    step();  // request at 8 outstanding, Inst/Inst_pc still hold word 4
    #2;
    Clrn = 1'b0;
    #1;
    checks++;
    if (bus.Imem_req !== 1'b0 || bus.Imem_addr !== 32'h0 || bus.Inst_valid !== 1'b0 ||
        bus.Inst !== 32'h0 || bus.Inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: req=%b addr=%h valid=%b inst=%h pc=%h, expected all 0",
               bus.Imem_req, bus.Imem_addr, bus.Inst_valid, bus.Inst, bus.Inst_pc);
    end
    @(negedge Clk);
    Clrn = 1'b1;
    step();
    do_fetch(32'h0);
  endtask

  initial begin
    Clrn = 1'b0;
    drive_idle();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_fetch();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
